// File: rtl/sc_commit_if.sv
// Bundle of the SC commit unit's pipeline-side and store-bus-side signals.
// The master side is the core/bus environment; the slave side is sc_commit.
interface sc_commit_if #(
   parameter int ADDR_W = 32
);
   logic              flush;
   logic              ll_valid;
   logic [ADDR_W-1:0] ll_addr;
   logic              sc_valid;
   logic [ADDR_W-1:0] sc_addr;
   logic [31:0]       sc_wdata;
   logic              sc_ready;
   logic              snoop_valid;
   logic [ADDR_W-1:0] snoop_addr;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic              resp_valid;
   logic              resp_result;
   logic              resv_valid;

   modport master (
      output flush, ll_valid, ll_addr, sc_valid, sc_addr, sc_wdata,
             snoop_valid, snoop_addr, mem_ack,
      input  sc_ready, mem_req, mem_addr, mem_wdata, resp_valid,
             resp_result, resv_valid
   );

   modport slave (
      input  flush, ll_valid, ll_addr, sc_valid, sc_addr, sc_wdata,
             snoop_valid, snoop_addr, mem_ack,
      output sc_ready, mem_req, mem_addr, mem_wdata, resp_valid,
             resp_result, resv_valid
   );
endinterface

// File: rtl/sc_commit.sv
// Store-conditional commit unit: tracks the LL reservation at granule
// resolution, issues the conditional store on the store bus when the
// reservation still holds, and reports the SC result as a one-cycle pulse.
module sc_commit #(
   parameter int ADDR_W   = 32,
   parameter int GRAN_LSB = 4
) (
   input  logic         clk,
   input  logic         rst,
   sc_commit_if.slave   sc_if
);

   localparam int TAG_W = ADDR_W - GRAN_LSB;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ACK = 2'd1,
      ST_RESP     = 2'd2
   } state_t;

   state_t            state_q,       state_d;
   logic              resv_valid_q,  resv_valid_d;
   logic [TAG_W-1:0]  resv_tag_q,    resv_tag_d;
   logic              mem_req_q,     mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
   logic [31:0]       mem_wdata_q,   mem_wdata_d;
   logic              resp_valid_q,  resp_valid_d;
   logic              resp_result_q, resp_result_d;
   // Set when a flush hits an in-flight store: the store finishes but reports nothing.
   logic              kill_q,        kill_d;

   logic sc_ready_s;
   logic accept_s;
   logic sc_match_s;
   logic snoop_hit_s;
   logic unused_lsb_s;

   assign sc_ready_s  = (state_q == ST_IDLE) && !sc_if.flush;
   assign accept_s    = sc_if.sc_valid && sc_ready_s;
   assign sc_match_s  = resv_valid_q && (sc_if.sc_addr[ADDR_W-1:GRAN_LSB] == resv_tag_q);
   assign snoop_hit_s = sc_if.snoop_valid && (sc_if.snoop_addr[ADDR_W-1:GRAN_LSB] == resv_tag_q);

   // Offsets inside the granule never take part in the reservation compare.
   assign unused_lsb_s = ^{sc_if.ll_addr[GRAN_LSB-1:0], sc_if.snoop_addr[GRAN_LSB-1:0]};

   assign sc_if.sc_ready    = sc_ready_s;
   assign sc_if.mem_req     = mem_req_q;
   assign sc_if.mem_addr    = mem_addr_q;
   assign sc_if.mem_wdata   = mem_wdata_q;
   // A flush arriving while the response is up suppresses it in that same cycle.
   assign sc_if.resp_valid  = resp_valid_q && !sc_if.flush;
   assign sc_if.resp_result = resp_result_q;
   assign sc_if.resv_valid  = resv_valid_q;

   // SC sequencing: decide next state, store-bus request and response pulse.
   always_comb begin
      state_d       = state_q;
      mem_req_d     = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      resp_valid_d  = 1'b0;
      resp_result_d = resp_result_q;
      kill_d        = kill_q;

      case (state_q)
         ST_IDLE: begin
            kill_d = 1'b0;
            if (accept_s) begin
               if (sc_match_s) begin
                  state_d     = ST_WAIT_ACK;
                  mem_req_d   = 1'b1;
                  mem_addr_d  = sc_if.sc_addr;
                  mem_wdata_d = sc_if.sc_wdata;
               end else begin
                  state_d       = ST_RESP;
                  resp_valid_d  = 1'b1;
                  resp_result_d = 1'b0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_WAIT_ACK: begin
            mem_req_d = 1'b1;
            if (sc_if.flush) begin
               kill_d = 1'b1;
            end else begin
               kill_d = kill_q;
            end
            if (sc_if.mem_ack) begin
               mem_req_d = 1'b0;
               if (kill_q || sc_if.flush) begin
                  state_d = ST_IDLE;
                  kill_d  = 1'b0;
               end else begin
                  state_d       = ST_RESP;
                  resp_valid_d  = 1'b1;
                  resp_result_d = 1'b1;
               end
            end else begin
               state_d = ST_WAIT_ACK;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            kill_d  = 1'b0;
         end
      endcase
   end

   // Reservation update: flush beats LL, LL beats snoop/SC clears.
   always_comb begin
      resv_valid_d = resv_valid_q;
      resv_tag_d   = resv_tag_q;
      if (sc_if.flush) begin
         resv_valid_d = 1'b0;
      end else if (sc_if.ll_valid) begin
         resv_valid_d = 1'b1;
         resv_tag_d   = sc_if.ll_addr[ADDR_W-1:GRAN_LSB];
      end else if (accept_s || snoop_hit_s) begin
         resv_valid_d = 1'b0;
      end else begin
         resv_valid_d = resv_valid_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         resv_valid_q  <= 1'b0;
         resv_tag_q    <= '0;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= 32'd0;
         resp_valid_q  <= 1'b0;
         resp_result_q <= 1'b0;
         kill_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         resv_valid_q  <= resv_valid_d;
         resv_tag_q    <= resv_tag_d;
         mem_req_q     <= mem_req_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         resp_valid_q  <= resp_valid_d;
         resp_result_q <= resp_result_d;
         kill_q        <= kill_d;
      end
   end

endmodule

// File: tb/tb_sc_commit.sv
// Self-checking bench for sc_commit: directed scenarios plus a randomized
// LL/snoop/flush/SC sequence checked against a granule-level reservation model.
module tb_sc_commit;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   sc_commit_if #(.ADDR_W(32)) bus ();

   sc_commit #(.ADDR_W(32), .GRAN_LSB(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .sc_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of LL / snoop / flush and return to idle inputs.
   task automatic drive_cycle(input bit ll, input logic [31:0] lla,
                              input bit sn, input logic [31:0] sna, input bit fl);
      bus.ll_valid    = ll;
      bus.ll_addr     = lla;
      bus.snoop_valid = sn;
      bus.snoop_addr  = sna;
      bus.flush       = fl;
      @(negedge clk);
      bus.ll_valid    = 1'b0;
      bus.snoop_valid = 1'b0;
      bus.flush       = 1'b0;
   endtask

   // Issue one SC and observe a fixed window after acceptance.
   // Cycle 1 of the window is the first cycle after the accept edge.
   task automatic run_sc(input logic [31:0] addr, input logic [31:0] data,
                         input int n_ack, input int flush_at,
                         output bit acc, output int mcount, output int rcount,
                         output bit rres, output int rlat,
                         output logic [31:0] maddr, output logic [31:0] mdata,
                         output bit mstable);
      acc = 1'b0; mcount = 0; rcount = 0; rres = 1'b0; rlat = 0;
      maddr = 32'd0; mdata = 32'd0; mstable = 1'b1;
      bus.sc_addr  = addr;
      bus.sc_wdata = data;
      bus.sc_valid = 1'b1;
      for (int w = 0; w < 20 && !acc; w++) begin
         #1;
         if (bus.sc_ready) acc = 1'b1;
         else @(negedge clk);
      end
      if (!acc) begin
         bus.sc_valid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.sc_valid = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         bus.flush = (cyc == flush_at);
         #1;
         if (bus.resp_valid) begin
            rcount++;
            if (rcount == 1) begin
               rres = bus.resp_result;
               rlat = cyc;
            end
         end
         if (bus.mem_req) begin
            mcount++;
            if (mcount == 1) begin
               maddr = bus.mem_addr;
               mdata = bus.mem_wdata;
            end else if (bus.mem_addr !== maddr || bus.mem_wdata !== mdata) begin
               mstable = 1'b0;
            end
            bus.mem_ack = (mcount == n_ack);
         end else begin
            bus.mem_ack = 1'b0;
         end
         @(negedge clk);
      end
      bus.flush   = 1'b0;
      bus.mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.ll_valid = 1'b1; bus.ll_addr = 32'h0000_7000;
      bus.flush = 1'b1; bus.mem_ack = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.resv_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.resp_valid !== 1'b0 ||
          bus.resp_result !== 1'b0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: resv=%b req=%b resp=%b res=%b addr=%h wd=%h, required all zero",
                  bus.resv_valid, bus.mem_req, bus.resp_valid, bus.resp_result,
                  bus.mem_addr, bus.mem_wdata);
      end
      bus.ll_valid = 1'b0; bus.flush = 1'b0; bus.mem_ack = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (bus.sc_ready !== 1'b1 || bus.resv_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: sc_ready=%b resv_valid=%b, required 1 0",
                  bus.sc_ready, bus.resv_valid);
      end
   endtask

   task automatic test_ll_sc_success();
      bit acc, rres, mst; int mc, rc, lat; logic [31:0] ma, md;
      drive_cycle(1'b1, 32'h0000_1000, 1'b0, 32'd0, 1'b0);
      checks++;
      if (bus.resv_valid !== 1'b1) begin
         errors++; $display("FAIL ll_sets_resv: got %b required 1", bus.resv_valid);
      end
      run_sc(32'h0000_1008, 32'h0000_DEAD, 3, 0, acc, mc, rc, rres, lat, ma, md, mst);
      checks++;
      if (!acc || mc != 3 || ma !== 32'h0000_1008 || md !== 32'h0000_DEAD || !mst) begin
         errors++;
         $display("FAIL success_store: acc=%b req_cycles=%0d addr=%h data=%h stable=%b, required 1 3 1008 dead 1",
                  acc, mc, ma, md, mst);
      end
      checks++;
      if (rc != 1 || rres !== 1'b1 || lat != 4 || bus.resv_valid !== 1'b0) begin
         errors++;
         $display("FAIL success_resp: pulses=%0d result=%b latency=%0d resv=%b, required 1 1 4 0",
                  rc, rres, lat, bus.resv_valid);
      end
   endtask

   task automatic test_snoop_kill();
      bit acc, rres, mst; int mc, rc, lat; logic [31:0] ma, md;
      drive_cycle(1'b1, 32'h0000_1000, 1'b0, 32'd0, 1'b0);
      drive_cycle(1'b0, 32'd0, 1'b1, 32'h0000_100C, 1'b0);
      checks++;
      if (bus.resv_valid !== 1'b0) begin
         errors++; $display("FAIL snoop_clears: resv=%b required 0", bus.resv_valid);
      end
      run_sc(32'h0000_1000, 32'h1234_5678, 1, 0, acc, mc, rc, rres, lat, ma, md, mst);
      checks++;
      if (!acc || mc != 0 || rc != 1 || rres !== 1'b0 || lat != 1) begin
         errors++;
         $display("FAIL snoop_kill_sc: acc=%b req_cycles=%0d pulses=%0d result=%b latency=%0d, required 1 0 1 0 1",
                  acc, mc, rc, rres, lat);
      end
   endtask

   task automatic test_snoop_other();
      bit acc, rres, mst; int mc, rc, lat; logic [31:0] ma, md;
      drive_cycle(1'b1, 32'h0000_1000, 1'b0, 32'd0, 1'b0);
      drive_cycle(1'b0, 32'd0, 1'b1, 32'h0000_1010, 1'b0);
      run_sc(32'h0000_1000, 32'hCAFE_0001, 1, 0, acc, mc, rc, rres, lat, ma, md, mst);
      checks++;
      if (!acc || mc != 1 || rc != 1 || rres !== 1'b1 || lat != 2 || ma !== 32'h0000_1000) begin
         errors++;
         $display("FAIL snoop_other_granule: acc=%b req_cycles=%0d pulses=%0d result=%b latency=%0d addr=%h, required 1 1 1 1 2 1000",
                  acc, mc, rc, rres, lat, ma);
      end
   endtask

   task automatic test_flush_wait();
      bit acc, rres, mst; int mc, rc, lat; logic [31:0] ma, md;
      drive_cycle(1'b1, 32'h0000_2000, 1'b0, 32'd0, 1'b0);
      run_sc(32'h0000_2000, 32'h0000_00AA, 3, 1, acc, mc, rc, rres, lat, ma, md, mst);
      checks++;
      if (!acc || mc != 3 || rc != 0 || bus.resv_valid !== 1'b0 || !mst) begin
         errors++;
         $display("FAIL flush_in_wait: acc=%b req_cycles=%0d pulses=%0d resv=%b stable=%b, required 1 3 0 0 1",
                  acc, mc, rc, bus.resv_valid, mst);
      end
      #1;
      checks++;
      if (bus.sc_ready !== 1'b1) begin
         errors++; $display("FAIL flush_wait_idle: sc_ready=%b required 1", bus.sc_ready);
      end
   endtask

   task automatic test_flush_resp();
      bit acc, rres, mst; int mc, rc, lat; logic [31:0] ma, md;
      run_sc(32'h0000_5000, 32'h0000_0055, 1, 1, acc, mc, rc, rres, lat, ma, md, mst);
      checks++;
      if (!acc || mc != 0 || rc != 0) begin
         errors++;
         $display("FAIL flush_in_resp: acc=%b req_cycles=%0d pulses=%0d, required 1 0 0", acc, mc, rc);
      end
   endtask

   task automatic test_priority();
      drive_cycle(1'b1, 32'h0000_3000, 1'b1, 32'h0000_3000, 1'b0);
      checks++;
      if (bus.resv_valid !== 1'b1) begin
         errors++; $display("FAIL ll_over_snoop: resv=%b required 1", bus.resv_valid);
      end
      drive_cycle(1'b1, 32'h0000_3000, 1'b0, 32'd0, 1'b1);
      checks++;
      if (bus.resv_valid !== 1'b0) begin
         errors++; $display("FAIL flush_over_ll: resv=%b required 0", bus.resv_valid);
      end
      bus.flush = 1'b1; bus.sc_valid = 1'b1; bus.sc_addr = 32'h0000_3000;
      #1;
      checks++;
      if (bus.sc_ready !== 1'b0) begin
         errors++; $display("FAIL ready_during_flush: sc_ready=%b required 0", bus.sc_ready);
      end
      @(negedge clk);
      bus.flush = 1'b0; bus.sc_valid = 1'b0;
      #1;
      checks++;
      if (bus.mem_req !== 1'b0 || bus.resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL sc_ignored_in_flush: req=%b resp=%b required 0 0", bus.mem_req, bus.resp_valid);
      end
   endtask

   task automatic test_back_to_back();
      bit acc, rres, mst; int mc, rc, lat; logic [31:0] ma, md;
      drive_cycle(1'b1, 32'h0000_1000, 1'b0, 32'd0, 1'b0);
      run_sc(32'h0000_1000, 32'h0000_0001, 2, 0, acc, mc, rc, rres, lat, ma, md, mst);
      checks++;
      if (!acc || mc != 2 || rres !== 1'b1 || rc != 1) begin
         errors++;
         $display("FAIL b2b_first: acc=%b req_cycles=%0d result=%b pulses=%0d, required 1 2 1 1", acc, mc, rres, rc);
      end
      run_sc(32'h0000_1000, 32'h0000_0002, 2, 0, acc, mc, rc, rres, lat, ma, md, mst);
      checks++;
      if (!acc || mc != 0 || rres !== 1'b0 || rc != 1) begin
         errors++;
         $display("FAIL b2b_second: acc=%b req_cycles=%0d result=%b pulses=%0d, required 1 0 0 1", acc, mc, rres, rc);
      end
   endtask

   task automatic test_reset_mid_store();
      drive_cycle(1'b1, 32'h0000_4000, 1'b0, 32'd0, 1'b0);
      bus.sc_valid = 1'b1; bus.sc_addr = 32'h0000_4004; bus.sc_wdata = 32'h0000_0BEE;
      @(negedge clk);
      bus.sc_valid = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b1) begin
         errors++; $display("FAIL store_started: req=%b required 1", bus.mem_req);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b0 || bus.resv_valid !== 1'b0 || bus.mem_addr !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_store: req=%b resv=%b addr=%h required 0 0 0",
                  bus.mem_req, bus.resv_valid, bus.mem_addr);
      end
      @(negedge clk);
   endtask

   // Reservation model: a valid flag and a 16-byte granule number.
   task automatic test_random();
      bit m_valid; logic [27:0] m_gran;
      bit acc, rres, mst; int mc, rc, lat; logic [31:0] ma, md;
      logic [31:0] a1, a2, wd; int op, nack; bit exp_ok;
      m_valid = 1'b0; m_gran = 28'd0;
      drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      for (int it = 0; it < 60; it++) begin
         op = $urandom_range(0, 5);
         a1 = 32'h0000_1000 + 32'd16 * $urandom_range(0, 3) + $urandom_range(0, 15);
         a2 = 32'h0000_1000 + 32'd16 * $urandom_range(0, 3) + $urandom_range(0, 15);
         if (op <= 2) begin
            drive_cycle(op != 1, a1, op != 0, a2, 1'b0);
            if (op != 1) begin
               m_valid = 1'b1; m_gran = a1[31:4];
            end else if (a2[31:4] == m_gran) begin
               m_valid = 1'b0;
            end
            checks++;
            if (bus.resv_valid !== m_valid) begin
               errors++;
               $display("FAIL rand_resv it=%0d op=%0d: resv=%b required %b", it, op, bus.resv_valid, m_valid);
            end
         end else if (op == 5) begin
            drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
            m_valid = 1'b0;
         end else begin
            nack = $urandom_range(1, 4);
            wd = $urandom;
            exp_ok = m_valid && (a1[31:4] == m_gran);
            run_sc(a1, wd, nack, 0, acc, mc, rc, rres, lat, ma, md, mst);
            m_valid = 1'b0;
            checks++;
            if (!acc || rc != 1 || rres !== exp_ok || lat != (exp_ok ? nack + 1 : 1) ||
                mc != (exp_ok ? nack : 0) || bus.resv_valid !== 1'b0) begin
               errors++;
               $display("FAIL rand_sc it=%0d addr=%h: acc=%b pulses=%0d result=%b latency=%0d req_cycles=%0d resv=%b, required result %b req_cycles %0d",
                        it, a1, acc, rc, rres, lat, mc, bus.resv_valid, exp_ok, exp_ok ? nack : 0);
            end
            if (exp_ok) begin
               checks++;
               if (ma !== a1 || md !== wd || !mst) begin
                  errors++;
                  $display("FAIL rand_store it=%0d: addr=%h data=%h stable=%b, required %h %h 1",
                           it, ma, md, mst, a1, wd);
               end
            end
         end
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1;
      bus.flush = 1'b0; bus.ll_valid = 1'b0; bus.ll_addr = 32'd0;
      bus.sc_valid = 1'b0; bus.sc_addr = 32'd0; bus.sc_wdata = 32'd0;
      bus.snoop_valid = 1'b0; bus.snoop_addr = 32'd0; bus.mem_ack = 1'b0;
      @(negedge clk);
      test_reset();
      test_ll_sc_success();
      test_snoop_kill();
      test_snoop_other();
      test_flush_wait();
      test_flush_resp();
      test_priority();
      test_back_to_back();
      test_reset_mid_store();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sc_commit.md
SC_COMMIT -- requirements
Module: sc_commit

Interface
REQ-001 Parameter ADDR_W, default 32, physical address width.
REQ-002 Parameter GRAN_LSB, default 4, low address bits ignored in reservation compare (16-byte granule).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  exception/ERET flush; kills reservation and pending response.
REQ-006 ll_valid  input  1  LL retiring this cycle; ll_addr  input  ADDR_W  its address.
REQ-007 sc_valid  input  1  SC request; sc_addr  input  ADDR_W; sc_wdata  input  32; sc_ready  output  1  SC accepted when sc_valid&&sc_ready.
REQ-008 snoop_valid  input  1  foreign write observed; snoop_addr  input  ADDR_W.
REQ-009 mem_req  output  1; mem_addr  output  ADDR_W; mem_wdata  output  32; mem_ack  input  1  store bus, transfer completes when mem_req&&mem_ack.
REQ-010 resp_valid  output  1  one-cycle pulse; resp_result  output  1  SC rt value (1 success, 0 fail).
REQ-011 resv_valid  output  1  current reservation flag, registered.

Function
REQ-012 Reservation = resv_valid plus resv_addr[ADDR_W-1:GRAN_LSB]; match = resv_valid && addr[ADDR_W-1:GRAN_LSB]==resv_addr.
REQ-013 FSM states IDLE, WAIT_ACK, RESP; sc_ready = (state==IDLE) && !flush.
REQ-014 IDLE, SC accepted with match: latch sc_addr/sc_wdata, go WAIT_ACK; mem_req asserted from next cycle.
REQ-015 IDLE, SC accepted without match: go RESP with result 0; no mem_req ever asserted for that SC.
REQ-016 WAIT_ACK: mem_req held high, mem_addr/mem_wdata stable until mem_ack; on mem_ack go RESP with result 1 (mem_req low the cycle after ack).
REQ-017 RESP: resp_valid=1 for exactly one cycle, then IDLE; success latency = ack cycle +1, fail latency = accept cycle +1.
REQ-018 Any accepted SC clears the reservation at the accept edge, regardless of outcome.
REQ-019 ll_valid sets resv_valid=1 and resv_addr from ll_addr; ll_valid overrides snoop clear and SC clear in the same cycle.
REQ-020 snoop_valid with granule match clears resv_valid; non-matching snoop has no effect; snoop in WAIT_ACK does not abort the store.
REQ-021 flush clears resv_valid (overrides ll_valid); in IDLE or RESP forces IDLE with no resp_valid that cycle or after.
REQ-022 flush in WAIT_ACK: bus transaction not aborted, mem_req held until mem_ack, then IDLE with no resp_valid.
REQ-023 sc_valid during flush not accepted; sc_valid in WAIT_ACK/RESP held by requester until sc_ready.
REQ-024 mem_req never asserted outside WAIT_ACK; at most one outstanding store.

Reset
REQ-025 rst: state IDLE, resv_valid 0, resv_addr 0, mem_req 0, resp_valid 0, resp_result 0, mem_addr/mem_wdata 0.
REQ-026 rst dominates flush, ll_valid, mem_ack; rst mid-WAIT_ACK drops mem_req next cycle (bus reset jointly).
REQ-027 First cycle after rst release: sc_ready 1, resv_valid 0.

Verification
REQ-028 LL 0x1000, SC 0x1008 data 0xDEAD, ack after 3 cycles -> mem_req 3 cycles, mem_addr 0x1008, mem_wdata 0xDEAD, resp 1 next cycle, resv_valid 0.
REQ-029 LL 0x1000, snoop 0x100C, SC 0x1000 -> no mem_req, resp_valid with result 0 one cycle after accept.
REQ-030 LL 0x1000, snoop 0x1010, SC 0x1000 -> store issued, result 1.
REQ-031 LL 0x2000, SC accepted, flush while WAIT_ACK, ack 2 cycles later -> mem_req held to ack, no resp_valid, resv_valid 0.
REQ-032 Same cycle ll_valid 0x3000 and matching snoop 0x3000 -> resv_valid 1; same cycle ll_valid and flush -> resv_valid 0.
REQ-033 Back-to-back SC 0x1000 twice after one LL -> first result 1, second result 0 with no mem_req.
